// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial sequencer driving a 1-bit half_alu slice
// Optional feature macro: SERIAL_ALU_CHAIN_EN (adds carry_in for chained multi-word adds)
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
`ifdef SERIAL_ALU_CHAIN_EN
  input  logic             carry_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_o1,
  output logic             alu_o2,
  output logic             alu_o3,
  output logic             alu_cin,
  input  logic             alu_c,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [2:0]       opr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             seed;
  logic             last_bit;

`ifdef SERIAL_ALU_CHAIN_EN
  assign seed = (op == OP_ADD) & carry_in;
`else
  assign seed = 1'b0;
`endif

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sa/sb shift in zeros and opr/carry are cleared on the last bit, so the
  // slice drives below read 0 outside RUN straight from the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      opr       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa        <= opa;
            sb        <= opb;
            opr       <= op;
            cnt       <= '0;
            carry     <= seed;
            result    <= '0;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          result <= {alu_c, result[WIDTH-1:1]};
          if (last_bit) begin
            carry_out <= (opr == OP_ADD) & alu_cout;
            carry     <= 1'b0;
            opr       <= '0;
            cnt       <= '0;
          end else begin
            carry <= (opr == OP_ADD) & alu_cout;
            cnt   <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a   = sa[0];
  assign alu_b   = sb[0];
  assign alu_o1  = opr[2];
  assign alu_o2  = opr[1];
  assign alu_o3  = opr[0];
  assign alu_cin = carry;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - randomized self-checking bench for serial_alu_seq
// Build with SERIAL_ALU_CHAIN_EN defined to exercise the carry_in chaining checks.
module tb_serial_alu_seq;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin_drv;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         alu_a, alu_b, alu_o1, alu_o2, alu_o3, alu_cin;
  logic         alu_c, alu_cout;

  int tests = 0;
  int fails = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
`ifdef SERIAL_ALU_CHAIN_EN
    .carry_in(cin_drv),
`endif
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_o1(alu_o1), .alu_o2(alu_o2),
    .alu_o3(alu_o3), .alu_cin(alu_cin), .alu_c(alu_c), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational half_alu slice the sequencer talks to
  always_comb begin
    alu_c    = 1'b0;
    alu_cout = 1'b0;
    case ({alu_o1, alu_o2, alu_o3})
      3'b000: alu_c = alu_a;
      3'b001: alu_c = alu_b;
      3'b010: alu_c = ~alu_a;
      3'b011: alu_c = ~alu_b;
      3'b100: alu_c = alu_a & alu_b;
      3'b101: alu_c = alu_a | alu_b;
      3'b110: alu_c = alu_a ^ alu_b;
      default: begin
        alu_c    = alu_a ^ alu_b ^ alu_cin;
        alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b));
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic eff_cin(input logic [2:0] o, input logic ci);
`ifdef SERIAL_ALU_CHAIN_EN
    return (o == 3'b111) & ci;
`else
    return 1'b0 & ci & o[0];
`endif
  endfunction

  // Word-level reference: {carry, result}
  function automatic logic [W:0] ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic ci);
    logic [W:0] s;
    case (o)
      3'd0: s = {1'b0, a};
      3'd1: s = {1'b0, b};
      3'd2: s = {1'b0, ~a};
      3'd3: s = {1'b0, ~b};
      3'd4: s = {1'b0, a & b};
      3'd5: s = {1'b0, a | b};
      3'd6: s = {1'b0, a ^ b};
      default: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endcase
    return s;
  endfunction

  function automatic logic [5:0] slice_bus();
    return {alu_a, alu_b, alu_o1, alu_o2, alu_o3, alu_cin};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit disturb);
    logic [W:0] exp;
    int busy_n, done_n, done_at;
    exp = ref_model(o, a, b, eff_cin(o, ci));
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin_drv = ci;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); opa = W'($urandom); opb = W'($urandom); cin_drv = 1'($urandom);
    busy_n = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("first_bit_drive", 32'(slice_bus()), 32'({a[0], b[0], o, eff_cin(o, ci)}));
        check("result_cleared", 32'(result), 32'(0));
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        check("result", 32'(result), 32'(exp[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(exp[W]));
      end
      if (disturb && (i == 3 || i == W + 1)) begin
        start = 1'b1; op = 3'b111; opa = W'($urandom); opb = W'($urandom);
      end
      if (disturb && (i == 4 || i == W + 2)) start = 1'b0;
    end
    check("busy_cycles", 32'(busy_n), 32'(W));
    check("done_count", 32'(done_n), 32'(1));
    check("done_cycle", 32'(done_at), 32'(W + 1));
    check("result_held", 32'(result), 32'(exp[W-1:0]));
    check("carry_held", 32'(carry_out), 32'(exp[W]));
    check("idle_slice_zero", 32'(slice_bus()), 32'(0));
  endtask

  task automatic reset_abort();
    int done_n;
    @(negedge clk);
    start = 1'b1; op = 3'b111; opa = 8'h55; opb = 8'h77; cin_drv = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs",
          32'({busy, done, result, carry_out, slice_bus()}), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin_drv = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, result, carry_out, slice_bus()}), 32'(0));
    rst = 1'b0;

    run_op(3'b111, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(3'b100, 8'hA5, 8'h3C, 1'b0, 1'b0);
    run_op(3'b110, 8'hA5, 8'h3C, 1'b0, 1'b0);
    run_op(3'b010, 8'h0F, 8'h00, 1'b0, 1'b0);
    run_op(3'b111, 8'h12, 8'h34, 1'b0, 1'b1);
    reset_abort();
    run_op(3'b111, 8'h10, 8'h20, 1'b0, 1'b0);
`ifdef SERIAL_ALU_CHAIN_EN
    run_op(3'b111, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op(3'b100, 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(3'b111, 8'hFF, 8'h00, 1'b1, 1'b0);
`endif
    for (int n = 0; n < 24; n++) begin
      run_op(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
